ram_b_arbiter: RTL

- Owns RAM port B (the screen-side port) and shares it between three requesters: the VGA fetch path, a debug/monitor single-word access channel, and a built-in bulk clear/fill engine.
- Replaces the crude "write 0 while reset is held" clearing of port B.
- Sits between the RAM instance and the vga/hex_display/perf logic, in the CLK_50 domain.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_clear_engine.sv | 79 +++++++
 rtl/ram_b_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port B arbiter and its clear engine.
package ram_arb_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_DBG,
        OWN_CLR
    } owner_e;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DONE
    } clr_state_e;

endpackage

// File: rtl/ram_clear_engine.sv
// Bulk clear/fill engine: walks base..base+count-1 (wrapping), one word per granted cycle.
module ram_clear_engine
    import ram_arb_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   count,
    input  logic [DW-1:0] fill,
    input  logic          granted,
    output logic          req,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          busy,
    output logic          done
);

    clr_state_e    state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW-1:0] base_q;
    logic [AW:0]   count_q;
    logic [DW-1:0] fill_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the job parameters are plain datapath registers with no reset; they are
    // only consumed in RUN, which can be entered solely through the load below.
    always_ff @(posedge clk) begin
        if (state_q == CLR_IDLE && start) begin
            base_q  <= base;
            count_q <= count;
            fill_q  <= fill;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = (count == '0) ? CLR_DONE : CLR_RUN;
                end
            end
            CLR_RUN: begin
                if (granted) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == count_q - 1'b1) begin
                        state_d = CLR_DONE;
                    end
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    // Truncating to AW bits makes the fill wrap past the top of memory.
    assign addr = base_q + idx_q[AW-1:0];
    assign data = fill_q;
    assign req  = (state_q == CLR_RUN);
    assign busy = (state_q == CLR_RUN);
    assign done = (state_q == CLR_DONE);

endmodule

// File: rtl/ram_b_arbiter.sv
// RAM port B owner: fixed priority VGA > debug > clear engine, plus the debug read pipeline.
// Optional stall counter on dbg_stall_cycles when RAM_B_ARB_PERF_EN is defined.
module ram_b_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH         = 16,
    parameter  int RAM_REGISTER_COUNT = 1024,
    localparam int AW                 = $clog2(RAM_REGISTER_COUNT),
    localparam int DW                 = DATA_WIDTH
) (
    input  logic                   CLK_50,
    input  logic                   reset,
    input  logic                   vga_req,
    input  logic [AW-1:0]          vga_addr,
    output logic [DW-1:0]          vga_rdata,
    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic [AW-1:0]          dbg_addr,
    input  logic [DW-1:0]          dbg_wdata,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [DW-1:0]          dbg_rdata,
    output logic [STALL_CNT_W-1:0] dbg_stall_cycles,
    input  logic                   clr_start,
    input  logic [AW-1:0]          clr_base,
    input  logic [AW:0]            clr_count,
    input  logic [DW-1:0]          clr_fill,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic [AW-1:0]          ram_addr_b,
    output logic [DW-1:0]          ram_data_b,
    output logic                   ram_wren_b,
    input  logic [DW-1:0]          ram_q_b
);

    owner_e        owner;
    logic          clr_req;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] clr_data;
    logic          rd_pend_q;

    ram_clear_engine #(
        .DW (DW),
        .AW (AW)
    ) u_clear (
        .clk     (CLK_50),
        .reset   (reset),
        .start   (clr_start),
        .base    (clr_base),
        .count   (clr_count),
        .fill    (clr_fill),
        .granted (owner == OWN_CLR),
        .req     (clr_req),
        .addr    (clr_addr),
        .data    (clr_data),
        .busy    (clr_busy),
        .done    (clr_done)
    );

    always_comb begin
        owner = OWN_NONE;
        if (vga_req)      owner = OWN_VGA;
        else if (dbg_req) owner = OWN_DBG;
        else if (clr_req) owner = OWN_CLR;
    end

    always_comb begin
        ram_addr_b = vga_addr;
        ram_data_b = dbg_wdata;
        ram_wren_b = 1'b0;
        unique case (owner)
            OWN_DBG: begin
                ram_addr_b = dbg_addr;
                ram_data_b = dbg_wdata;
                ram_wren_b = dbg_we;
            end
            OWN_CLR: begin
                ram_addr_b = clr_addr;
                ram_data_b = clr_data;
                ram_wren_b = 1'b1;
            end
            default: ;
        endcase
        // The mux stays live in reset so VGA keeps reading, but nothing may be written.
        if (reset) ram_wren_b = 1'b0;
    end

    assign dbg_gnt   = (owner == OWN_DBG);
    assign vga_rdata = ram_q_b;

    // Read granted at T: q_b valid at T+1, captured, and flagged with rvalid at T+2.
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            rd_pend_q  <= dbg_gnt && !dbg_we;
            dbg_rvalid <= rd_pend_q;
            if (rd_pend_q) dbg_rdata <= ram_q_b;
        end
    end

`ifdef RAM_B_ARB_PERF_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge CLK_50) begin
        if (reset || clr_start) begin
            stall_q <= '0;
        end else if (dbg_req && !dbg_gnt && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign dbg_stall_cycles = stall_q;
`else
    assign dbg_stall_cycles = '0;
`endif

endmodule
